imm_extend_pipe: RTL
====================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IMM_W, default 16, immediate field width.
REQ-002 SHALL have parameter DATA_W, default 32, extended result width; IMM_W+2 <= DATA_W.
REQ-003 SHALL have parameter TAG_W, default 32, width of sideband tag carried with each item.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  producer offers an item.
REQ-007 in_ready  output  1  block can accept an item this cycle.
REQ-008 in_imm  input  IMM_W  raw immediate.
REQ-009 in_op  input  2  mode: 0 sign, 1 zero, 2 high-load, 3 branch offset.
REQ-010 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-011 flush  input  1  synchronous discard of all buffered and offered items.
REQ-012 out_valid  output  1  out_data/out_tag hold a valid item.
REQ-013 out_ready  input  1  consumer accepts the item this cycle.
REQ-014 out_data  output  DATA_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of the item on out_data.
REQ-016 ext_cnt  output  16  completed-transfer count (see Configuration).

Function
REQ-017 Transfer-in SHALL occur on a rising edge where in_valid && in_ready && !flush; transfer-out SHALL occur where out_valid && out_ready && !flush.
REQ-018 Mode 0 SHALL produce in_imm sign-extended to DATA_W; mode 1 SHALL produce in_imm zero-extended.
REQ-019 Mode 2 SHALL produce in_imm in the top IMM_W bits with zeros below.
REQ-020 Mode 3 SHALL produce in_imm sign-extended and shifted left by 2, discarding overflowed top bits.
REQ-021 Extension SHALL be computed at transfer-in and stored; stored results SHALL be unaffected by later in_op changes.
REQ-022 Storage SHALL be a 2-entry FIFO; states EMPTY, ONE, FULL.
REQ-023 Transitions: push only -> occupancy +1; pop only -> occupancy -1; push and pop together -> unchanged.
REQ-024 in_ready SHALL equal (state != FULL), registered-state-derived, no combinational path from out_ready.
REQ-025 out_valid SHALL equal (state != EMPTY); out_data/out_tag SHALL present the oldest entry.
REQ-026 Latency SHALL be one cycle: item accepted at edge N is visible on out_* after edge N.
REQ-027 Items SHALL leave in acceptance order; none duplicated or dropped except by flush or reset.
REQ-028 flush SHALL have priority: at that edge, state -> EMPTY, any offered input discarded, no transfer-out counted.
REQ-029 While out_valid && !out_ready, out_data and out_tag SHALL remain stable.
REQ-030 When EMPTY, out_data and out_tag SHALL be 0.

Reset
REQ-031 rst_n low SHALL immediately force state EMPTY, out_valid 0, out_data 0, out_tag 0, ext_cnt 0, independent of clk.
REQ-032 in_ready SHALL be 1 during and after reset.
REQ-033 Reset asserted mid-operation SHALL discard all stored items; first transfer-in SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-034 Macro EXT_CNT_EN SHALL control the transfer counter.
REQ-035 With EXT_CNT_EN defined, ext_cnt SHALL increment by 1 per transfer-out and saturate at 0xFFFF.
REQ-036 Without EXT_CNT_EN, ext_cnt SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-037 Defaults; push in_imm=0x8001 op0, then 0x8001 op1, out_ready=1 -> out_data 0xFFFF8001 then 0x00008001, each one cycle after its accept.
REQ-038 Push 0x1234 op2, then 0xFFFF op3 -> out_data 0x12340000, then 0xFFFFFFFC; tags echoed exactly.
REQ-039 out_ready=0, offer 3 items tagged 1,2,3 -> in_ready 0 after second accept; third held; raise out_ready -> tags 1,2,3 in order, out_data stable while stalled.
REQ-040 FULL with in_valid=1, assert flush one cycle -> next cycle out_valid 0, in_ready 1, offered item absent from output.
REQ-041 Drop rst_n asynchronously between edges while FULL -> out_valid, out_data, ext_cnt 0 immediately; next item accepted on first edge after release.
REQ-042 With EXT_CNT_EN, 65540 transfers -> ext_cnt 0xFFFF; without EXT_CNT_EN -> ext_cnt 0 throughout.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage: a 2-entry ready/valid FIFO that stores extended immediates with their tags.
// Define EXT_CNT_EN to build the saturating completed-transfer counter on ext_cnt; otherwise ext_cnt is tied to 0.
module imm_extend_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [15:0]       ext_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, next_state;
  logic push, pop;
  logic [DATA_W-1:0] sext, ext;
  logic [DATA_W-1:0] data0, data1;
  logic [TAG_W-1:0]  tag0, tag1;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    case (in_op)
      2'd0:    ext = sext;
      2'd1:    ext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      2'd2:    ext = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      default: ext = sext << 2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) next_state = ONE;
        ONE: begin
          if (push && !pop)      next_state = FULL;
          else if (pop && !push) next_state = EMPTY;
        end
        FULL:    if (pop) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Slot 0 always holds the oldest item; a pop shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
      tag0  <= '0;
      tag1  <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (push) begin
          data0 <= ext;
          tag0  <= in_tag;
        end
        ONE: begin
          if (push && pop) begin
            data0 <= ext;
            tag0  <= in_tag;
          end else if (push) begin
            data1 <= ext;
            tag1  <= in_tag;
          end
        end
        FULL: if (pop) begin
          data0 <= data1;
          tag0  <= tag1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    out_data  = out_valid ? data0 : '0;
    out_tag   = out_valid ? tag0  : '0;
  end

`ifdef EXT_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (pop && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  assign ext_cnt = cnt;
`else
  assign ext_cnt = '0;
`endif

endmodule
